// File: rtl/fetch_pkg.sv
// Types and constants shared by the fetch PC register and its branch target buffer.
package fetch_pkg;
  localparam int INST_BYTES = 4;
  // BTB entry fields are sized for the widest supported PC and zero-extended by users.
  localparam int BTB_W_MAX  = 64;

  typedef struct packed {
    logic                 valid;
    logic [BTB_W_MAX-1:0] tag;
    logic [BTB_W_MAX-1:0] target;
  } btb_entry_t;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_BR,
    SEL_STALL,
    SEL_PRED,
    SEL_SEQ
  } pc_sel_e;
endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup port, registered update port.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lkp_pc_i,
  output logic            lkp_hit_o,
  output logic [XLEN-1:0] lkp_tgt_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_tgt_i,
  input  logic            upd_taken_i
);
  localparam int IDX = $clog2(DEPTH);

  btb_entry_t           mem_q [DEPTH];
  logic [IDX-1:0]       lkp_idx, upd_idx;
  logic [BTB_W_MAX-1:0] lkp_tag, upd_tag;
  logic                 unused_lo;

  assign lkp_idx   = lkp_pc_i[2 +: IDX];
  assign upd_idx   = upd_pc_i[2 +: IDX];
  assign lkp_tag   = BTB_W_MAX'(lkp_pc_i[XLEN-1:2+IDX]);
  assign upd_tag   = BTB_W_MAX'(upd_pc_i[XLEN-1:2+IDX]);
  assign unused_lo = ^{lkp_pc_i[1:0], upd_pc_i[1:0]};

  // Reads see registered contents, so a same-cycle update is visible only next cycle.
  assign lkp_hit_o = mem_q[lkp_idx].valid && (mem_q[lkp_idx].tag == lkp_tag);
  assign lkp_tgt_o = mem_q[lkp_idx].target[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i].valid <= 1'b0;
    end else if (upd_valid_i) begin
      if (upd_taken_i) begin
        mem_q[upd_idx].valid  <= 1'b1;
        mem_q[upd_idx].tag    <= upd_tag;
        mem_q[upd_idx].target <= BTB_W_MAX'(upd_tgt_i & ~XLEN'(INST_BYTES-1));
      end else if (mem_q[upd_idx].tag == upd_tag) begin
        mem_q[upd_idx].valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/fetch_pc.sv
// Fetch PC register with trap/branch/stall/prediction priority mux.
// Define FETCH_PC_BTB_EN to build in the branch target buffer predictor.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_stall,
  input  logic            br_ctrl,
  input  logic [XLEN-1:0] br_addr,
  input  logic            trap_ctrl,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            btb_upd_valid,
  input  logic [XLEN-1:0] btb_upd_pc,
  input  logic [XLEN-1:0] btb_upd_target,
  input  logic            btb_upd_taken,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o
);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES-1);

  logic [XLEN-1:0] pc_q, pc_d, pred_tgt;
  logic            pred_hit;
  pc_sel_e         sel;

`ifdef FETCH_PC_BTB_EN
  fetch_btb #(.XLEN(XLEN), .DEPTH(BTB_DEPTH)) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lkp_pc_i   (pc_q),
    .lkp_hit_o  (pred_hit),
    .lkp_tgt_o  (pred_tgt),
    .upd_valid_i(btb_upd_valid),
    .upd_pc_i   (btb_upd_pc),
    .upd_tgt_i  (btb_upd_target),
    .upd_taken_i(btb_upd_taken)
  );
`else
  logic unused_upd;
  assign pred_hit   = 1'b0;
  assign pred_tgt   = '0;
  assign unused_upd = ^{btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken};
`endif

  always_comb begin
    sel = SEL_SEQ;
    if (trap_ctrl)     sel = SEL_TRAP;
    else if (br_ctrl)  sel = SEL_BR;
    else if (pc_stall) sel = SEL_STALL;
    else if (pred_hit) sel = SEL_PRED;
  end

  // Sequential path wraps naturally at 2^XLEN.
  always_comb begin
    pc_d = pc_q + XLEN'(INST_BYTES);
    case (sel)
      SEL_TRAP:  pc_d = trap_addr & ALIGN_MASK;
      SEL_BR:    pc_d = br_addr & ALIGN_MASK;
      SEL_STALL: pc_d = pc_q;
      SEL_PRED:  pc_d = pred_tgt & ALIGN_MASK;
      default:   pc_d = pc_q + XLEN'(INST_BYTES);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) pc_q <= RESET_VEC;
    else      pc_q <= pc_d;
  end

  assign pc_o         = pc_q;
  assign pred_taken_o = pred_hit;
endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc: expectations queued per driven cycle, compared after the edge.
module tb_fetch_pc;
`ifdef FETCH_PC_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic        pc_stall = 0, br_ctrl = 0, trap_ctrl = 0;
  logic [31:0] br_addr = 0, trap_addr = 0;
  logic        upd_valid = 0, upd_taken = 0;
  logic [31:0] upd_pc = 0, upd_tgt = 0;
  logic [31:0] pc;
  logic        pred;
  logic [7:0]  pc8, br8, tr8, up8;
  logic        pred8;

  int errs = 0, checks = 0;

  typedef struct { logic [31:0] pc; logic pred; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_pc #(.XLEN(32), .RESET_VEC(32'h100), .BTB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc_stall(pc_stall), .br_ctrl(br_ctrl), .br_addr(br_addr),
    .trap_ctrl(trap_ctrl), .trap_addr(trap_addr), .btb_upd_valid(upd_valid),
    .btb_upd_pc(upd_pc), .btb_upd_target(upd_tgt), .btb_upd_taken(upd_taken),
    .pc_o(pc), .pred_taken_o(pred)
  );

  assign br8 = 8'h0;
  assign tr8 = 8'h0;
  assign up8 = 8'h0;
  fetch_pc #(.XLEN(8), .RESET_VEC(8'hF8)) dut8 (
    .clk(clk), .rst(rst), .pc_stall(1'b0), .br_ctrl(1'b0), .br_addr(br8),
    .trap_ctrl(1'b0), .trap_addr(tr8), .btb_upd_valid(1'b0),
    .btb_upd_pc(up8), .btb_upd_target(up8), .btb_upd_taken(1'b0),
    .pc_o(pc8), .pred_taken_o(pred8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] exp_pc, input logic exp_pred);
    exp_t e;
    sb.push_back('{exp_pc, exp_pred});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("pc@%h", e.pc), pc, e.pc);
    chk($sformatf("pred@%h", e.pc), {31'b0, pred}, {31'b0, e.pred});
  endtask

  task automatic clr();
    pc_stall = 0; br_ctrl = 0; trap_ctrl = 0; upd_valid = 0; upd_taken = 0;
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
    upd_valid = 1; upd_pc = p; upd_tgt = t; upd_taken = tk;
  endtask

  task automatic br(input logic [31:0] a);
    br_ctrl = 1; br_addr = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // reset, with redirects asserted to show reset dominates
    trap_ctrl = 1; trap_addr = 32'h80; upd(32'h20, 32'h300, 1);
    cyc(32'h100, 0);
    clr();
    cyc(32'h100, 0);
    chk("x8_rst", {24'b0, pc8}, 32'hF8);
    chk("x8_pred", {31'b0, pred8}, 32'h0);
    rst = 1;
    cyc(32'h104, 0);
    chk("x8_seq", {24'b0, pc8}, 32'hFC);
    cyc(32'h108, 0);
    chk("x8_wrap", {24'b0, pc8}, 32'h00);
    cyc(32'h10C, 0);

    // trap beats branch and stall
    trap_ctrl = 1; trap_addr = 32'h80; br(32'h200); pc_stall = 1;
    cyc(32'h80, 0);
    clr();
    br(32'h40);
    cyc(32'h40, 0);
    clr(); pc_stall = 1;
    cyc(32'h40, 0); cyc(32'h40, 0); cyc(32'h40, 0);
    br(32'h203);
    cyc(32'h200, 0);
    clr();
    cyc(32'h204, 0);
    trap_ctrl = 1; trap_addr = 32'h87;
    cyc(32'h84, 0);
    clr();

    // taken entry at 0x20, then clear it
    upd(32'h20, 32'h300, 1);
    cyc(32'h88, 0);
    clr(); br(32'h20);
    cyc(32'h20, BTB);
    clr();
    cyc(BTB ? 32'h300 : 32'h24, 0);
    upd(32'h20, 32'h0, 0);
    cyc(BTB ? 32'h304 : 32'h28, 0);
    clr(); br(32'h20);
    cyc(32'h20, 0);
    clr();
    cyc(32'h24, 0);

    // update and lookup to same index: lookup uses old contents
    upd(32'h24, 32'h403, 1);
    cyc(32'h28, 0);
    clr(); br(32'h24);
    cyc(32'h24, BTB);
    clr();
    cyc(BTB ? 32'h400 : 32'h28, 0);

    // alias at index 0: 0x10 vs 0x50
    upd(32'h10, 32'h500, 1);
    cyc(BTB ? 32'h404 : 32'h2C, 0);
    clr(); br(32'h50);
    cyc(32'h50, 0);
    clr(); upd(32'h50, 32'h0, 0);
    cyc(32'h54, 0);
    clr(); br(32'h10);
    cyc(32'h10, BTB);
    clr();
    cyc(BTB ? 32'h500 : 32'h14, 0);

    // update proceeds during stall and replaces the occupant
    pc_stall = 1; upd(32'h30, 32'h600, 1);
    cyc(BTB ? 32'h500 : 32'h14, 0);
    clr(); br(32'h30);
    cyc(32'h30, BTB);
    br(32'h10);
    cyc(32'h10, 0);
    clr();

    // mid-run reset drops prediction state
    rst = 0; trap_ctrl = 1; trap_addr = 32'h80; upd(32'h34, 32'h700, 1);
    cyc(32'h100, 0);
    clr(); rst = 1; br(32'h30);
    cyc(32'h30, 0);
    clr();
    cyc(32'h34, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
